rewire_dev_driver: RTL and testbench

- Host-side driver for a ReWire-generated lock-step device: one byte in on `__in0` and one byte out on `__out0` every clock, with no flow control.
- Converts a valid/ready byte stream into that lock-step interface and collects the device's responses into a valid/ready output stream.
- Credit-based issuing ensures no response is ever dropped.
- Also generates the device's active-high reset from the driver's reset.

---
 rtl/rewire_drv_pkg.sv | 16 +
 rtl/rewire_drv_fifo.sv | 75 +++++++
 rtl/rewire_dev_driver.sv | 153 +++++++++++++++
 tb/tb_rewire_dev_driver.sv | 288 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/rewire_drv_pkg.sv
// Shared types and helpers for the ReWire lock-step device driver.
// Holds the byte type, the credit-width helper and the idle-byte default.
package rewire_drv_pkg;

    localparam int DRV_DATA_W = 8;

    typedef logic [DRV_DATA_W-1:0] byte_t;

    localparam byte_t IDLE_BYTE_DEF = 8'h00;

    // Enough bits to hold 0..depth inclusive.
    function automatic int credit_width(input int depth);
        return $clog2(depth) + 1;
    endfunction

endpackage

// File: rtl/rewire_drv_fifo.sv
// Response FIFO for the ReWire device driver: synchronous, async active-low reset.
// Ports: clk, rst_n, push/push_data, pop, head_data (0 when empty), full, empty, count.
module rewire_drv_fifo
    import rewire_drv_pkg::*;
#(
    parameter int DATA_W = 8,
    parameter int DEPTH  = 4
) (
    input  logic                            clk,
    input  logic                            rst_n,
    input  logic                            push,
    input  logic [DATA_W-1:0]               push_data,
    input  logic                            pop,
    output logic [DATA_W-1:0]               head_data,
    output logic                            full,
    output logic                            empty,
    output logic [credit_width(DEPTH)-1:0]  count
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = credit_width(DEPTH);

    logic [DATA_W-1:0] mem_q [DEPTH];
    logic [DATA_W-1:0] mem_d [DEPTH];
    logic [AW-1:0]     wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]     rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]     count_q, count_d;
    logic              do_push;
    logic              do_pop;

    assign full      = (count_q == CW'(DEPTH));
    assign empty     = (count_q == '0);
    assign count     = count_q;
    assign head_data = empty ? '0 : mem_q[rd_ptr_q];

    always_comb begin
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        do_pop   = pop && !empty;
        // A pop frees the head slot before the write lands, so a
        // simultaneous push into a full FIFO is still safe.
        do_push  = push && (!full || do_pop);
        if (do_push) begin
            mem_d[wr_ptr_q] = push_data;
            wr_ptr_d        = wr_ptr_q + AW'(1);
        end
        if (do_pop) begin
            rd_ptr_d = rd_ptr_q + AW'(1);
        end
        case ({do_push, do_pop})
            2'b10:   count_d = count_q + CW'(1);
            2'b01:   count_d = count_q - CW'(1);
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            mem_q    <= mem_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

endmodule

// File: rtl/rewire_dev_driver.sv
// Host driver for a ReWire lock-step device: valid/ready byte stream in,
// one byte per clock to the device, tagged responses back out via a FIFO.
// Ports: clk, rst (async, active-low), s_valid/s_ready/s_data (input stream),
// dev_in/dev_out/dev_rst (device side), m_valid/m_ready/m_data (responses).
// Optional macro REWIRE_DRV_STATS_EN adds issued_cnt and returned_cnt
// (16-bit saturating counters of issued bytes and popped responses).
module rewire_dev_driver
    import rewire_drv_pkg::*;
#(
    parameter int                DATA_W    = DRV_DATA_W,
    parameter int                LAT       = 0,
    parameter int                DEPTH     = 4,
    parameter logic [DATA_W-1:0] IDLE_BYTE = IDLE_BYTE_DEF,
    parameter int                RST_HOLD  = 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              s_valid,
    output logic              s_ready,
    input  logic [DATA_W-1:0] s_data,
    output logic [DATA_W-1:0] dev_in,
    input  logic [DATA_W-1:0] dev_out,
    output logic              dev_rst,
    output logic              m_valid,
    input  logic              m_ready,
    output logic [DATA_W-1:0] m_data
`ifdef REWIRE_DRV_STATS_EN
    ,
    output logic [15:0]       issued_cnt,
    output logic [15:0]       returned_cnt
`endif
);

    localparam int CW  = credit_width(DEPTH);
    // Keep a one-bit vector when LAT is 0 so the declarations stay legal;
    // in that build the vector is held at zero and never tags anything.
    localparam int IFW = (LAT > 0) ? LAT : 1;

    logic [RST_HOLD-1:0] rst_sr_q, rst_sr_d;
    logic [IFW-1:0]      inflight_q, inflight_d;
    logic [CW-1:0]       fifo_count;
    logic [CW-1:0]       credit;
    logic                fifo_full;
    logic                fifo_empty;
    logic                issue;
    logic                tag;
    logic                pop;
    int                  occ;

    // Device reset: the shift register is all ones while rst is low and
    // drains one zero per edge, so dev_rst drops after RST_HOLD edges.
    assign dev_rst = rst_sr_q[RST_HOLD-1];

    // Every accepted byte owns either a FIFO slot or an inflight tag, so
    // the remaining credit is what can still be issued without overflow.
    always_comb begin
        occ = int'(fifo_count);
        for (int i = 0; i < IFW; i++) begin
            if (LAT > 0 && inflight_q[i]) begin
                occ = occ + 1;
            end
        end
        credit = CW'(DEPTH - occ);
    end

    assign s_ready = (credit != '0) && !dev_rst;
    assign issue   = s_valid && s_ready;
    assign dev_in  = issue ? s_data : IDLE_BYTE;

    // With LAT 0 the device answers in the same cycle, so the issue
    // itself marks the response to capture.
    assign tag = (LAT == 0) ? issue : inflight_q[IFW-1];

    assign m_valid = !fifo_empty;
    assign pop     = m_valid && m_ready;

    always_comb begin
        inflight_d = '0;
        if (LAT > 0) begin
            inflight_d[0] = issue;
            for (int i = 1; i < IFW; i++) begin
                inflight_d[i] = inflight_q[i-1];
            end
        end
    end

    always_comb begin
        rst_sr_d = '0;
        for (int i = 1; i < RST_HOLD; i++) begin
            rst_sr_d[i] = rst_sr_q[i-1];
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rst_sr_q   <= '1;
            inflight_q <= '0;
        end else begin
            rst_sr_q   <= rst_sr_d;
            inflight_q <= inflight_d;
        end
    end

    rewire_drv_fifo #(
        .DATA_W (DATA_W),
        .DEPTH  (DEPTH)
    ) u_fifo (
        .clk       (clk),
        .rst_n     (rst),
        .push      (tag),
        .push_data (dev_out),
        .pop       (pop),
        .head_data (m_data),
        .full      (fifo_full),
        .empty     (fifo_empty),
        .count     (fifo_count)
    );

    // Credit accounting guarantees a tagged response always finds a slot.
    a_no_overflow: assert property (
        @(posedge clk) disable iff (!rst) !(tag && fifo_full && !pop)
    );

`ifdef REWIRE_DRV_STATS_EN
    logic [15:0] issued_cnt_q, issued_cnt_d;
    logic [15:0] returned_cnt_q, returned_cnt_d;

    always_comb begin
        issued_cnt_d   = issued_cnt_q;
        returned_cnt_d = returned_cnt_q;
        if (issue && issued_cnt_q != 16'hFFFF) begin
            issued_cnt_d = issued_cnt_q + 16'd1;
        end
        if (pop && returned_cnt_q != 16'hFFFF) begin
            returned_cnt_d = returned_cnt_q + 16'd1;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            issued_cnt_q   <= '0;
            returned_cnt_q <= '0;
        end else begin
            issued_cnt_q   <= issued_cnt_d;
            returned_cnt_q <= returned_cnt_d;
        end
    end

    assign issued_cnt   = issued_cnt_q;
    assign returned_cnt = returned_cnt_q;
`endif

endmodule

// File: tb/tb_rewire_dev_driver.sv
// Bench for rewire_dev_driver: three instances (LAT 0, 1, 2) share stimulus,
// each checked every cycle against a queue-based response model.
module tb_rewire_dev_driver;
    import rewire_drv_pkg::*;

    localparam int DEPTH    = 4;
    localparam int RST_HOLD = 2;
    localparam int NI       = 3;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       sv  = 1'b0;
    logic       mr  = 1'b0;
    logic [7:0] sd  = 8'h00;

    int total = 0;
    int bad   = 0;
    int cyc   = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        logic [7:0] d;
        int         rdy;
    } ent_t;

    typedef struct {
        logic       sv;
        logic [7:0] sd;
        logic       exp_sr;
        logic [7:0] exp_di;
        logic       exp_mv;
        logic [7:0] exp_md;
    } vec_t;

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s actual=%h required=%h", nm, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    for (genvar g = 0; g < NI; g++) begin : g_lat
        logic       s_ready;
        logic       m_valid;
        logic       dev_rst;
        logic [7:0] dev_in;
        logic [7:0] dev_out;
        logic [7:0] m_data;
        logic [15:0] isc;
        logic [15:0] rtc;
        logic [7:0] dpipe [3];
        int         got_n = 0;
        logic [7:0] got_d [64];

        rewire_dev_driver #(
            .DATA_W    (8),
            .LAT       (g),
            .DEPTH     (DEPTH),
            .IDLE_BYTE (8'h00),
            .RST_HOLD  (RST_HOLD)
        ) u_dut (
            .clk          (clk),
            .rst          (rst),
            .s_valid      (sv),
            .s_ready      (s_ready),
            .s_data       (sd),
            .dev_in       (dev_in),
            .dev_out      (dev_out),
            .dev_rst      (dev_rst),
            .m_valid      (m_valid),
            .m_ready      (mr),
            .m_data       (m_data)
`ifdef REWIRE_DRV_STATS_EN
            ,
            .issued_cnt   (isc),
            .returned_cnt (rtc)
`endif
        );

`ifndef REWIRE_DRV_STATS_EN
        assign isc = 16'h0;
        assign rtc = 16'h0;
`endif

        // Device under drive: out = in ^ FF, delayed by g register stages.
        always @(posedge clk) begin
            if (dev_rst) begin
                for (int i = 0; i < 3; i++) dpipe[i] <= 8'h00;
            end else begin
                dpipe[0] <= dev_in;
                dpipe[1] <= dpipe[0];
                dpipe[2] <= dpipe[1];
            end
        end

        if (g == 0) begin : g_comb
            assign dev_out = dev_in ^ 8'hFF;
        end else begin : g_reg
            assign dev_out = dpipe[g-1] ^ 8'hFF;
        end

        // Reference: every accepted byte is an outstanding response that
        // becomes visible g+1 cycles later; outstanding count caps at DEPTH.
        ent_t        mq[$];
        int          hold = 0;
        logic [15:0] mis  = 0;
        logic [15:0] mre  = 0;
        logic        e_dr, e_sr, e_mv, iss;

        always @(negedge clk) begin
            if (!rst) begin
                chk($sformatf("L%0d_rst_s_ready", g), s_ready, 0);
                chk($sformatf("L%0d_rst_m_valid", g), m_valid, 0);
                chk($sformatf("L%0d_rst_m_data", g), m_data, 0);
                chk($sformatf("L%0d_rst_dev_in", g), dev_in, 0);
                chk($sformatf("L%0d_rst_dev_rst", g), dev_rst, 1);
`ifdef REWIRE_DRV_STATS_EN
                chk($sformatf("L%0d_rst_isc", g), isc, 0);
                chk($sformatf("L%0d_rst_rtc", g), rtc, 0);
`endif
                mq.delete();
                hold = 0;
                mis  = 0;
                mre  = 0;
            end else begin
                e_dr = (hold < RST_HOLD);
                e_sr = !e_dr && (mq.size() < DEPTH);
                iss  = sv && e_sr;
                e_mv = 1'b0;
                if (mq.size() > 0) e_mv = (mq[0].rdy <= cyc);
                chk($sformatf("L%0d_dev_rst", g), dev_rst, e_dr);
                chk($sformatf("L%0d_s_ready", g), s_ready, e_sr);
                chk($sformatf("L%0d_dev_in", g), dev_in, iss ? sd : 8'h00);
                chk($sformatf("L%0d_m_valid", g), m_valid, e_mv);
                if (e_mv) chk($sformatf("L%0d_m_data", g), m_data, mq[0].d);
`ifdef REWIRE_DRV_STATS_EN
                chk($sformatf("L%0d_isc", g), isc, mis);
                chk($sformatf("L%0d_rtc", g), rtc, mre);
`endif
                if (e_mv && mr) begin
                    void'(mq.pop_front());
                    if (mre != 16'hFFFF) mre++;
                end
                if (iss) begin
                    mq.push_back('{d: sd ^ 8'hFF, rdy: cyc + g + 1});
                    if (mis != 16'hFFFF) mis++;
                end
                if (hold < RST_HOLD) hold++;
                if (m_valid && mr && got_n < 64) begin
                    got_d[got_n] = m_data;
                    got_n++;
                end
            end
        end
    end

    vec_t tbl [5];
    int   n;
    bit   resumed;

    initial begin
        tbl[0] = '{sv: 1, sd: 8'h00, exp_sr: 1, exp_di: 8'h00, exp_mv: 0, exp_md: 8'h00};
        tbl[1] = '{sv: 1, sd: 8'h5A, exp_sr: 1, exp_di: 8'h5A, exp_mv: 1, exp_md: 8'hFF};
        tbl[2] = '{sv: 1, sd: 8'hFF, exp_sr: 1, exp_di: 8'hFF, exp_mv: 1, exp_md: 8'hA5};
        tbl[3] = '{sv: 0, sd: 8'h00, exp_sr: 1, exp_di: 8'h00, exp_mv: 1, exp_md: 8'h00};
        tbl[4] = '{sv: 0, sd: 8'h00, exp_sr: 1, exp_di: 8'h00, exp_mv: 0, exp_md: 8'h00};

        repeat (3) tick();
        rst = 1'b1;
        @(negedge clk);
        chk("rel0_dev_rst", g_lat[0].dev_rst, 1);
        chk("rel0_s_ready", g_lat[0].s_ready, 0);
        tick();
        @(negedge clk);
        chk("rel1_dev_rst", g_lat[0].dev_rst, 1);
        chk("rel1_s_ready", g_lat[0].s_ready, 0);
        tick();
        @(negedge clk);
        chk("rel2_dev_rst", g_lat[0].dev_rst, 0);
        chk("rel2_s_ready", g_lat[0].s_ready, 1);
        tick();

        mr = 1'b1;
        for (int i = 0; i < 5; i++) begin
            sv = tbl[i].sv;
            sd = tbl[i].sd;
            @(negedge clk);
            chk($sformatf("tbl%0d_s_ready", i), g_lat[0].s_ready, tbl[i].exp_sr);
            chk($sformatf("tbl%0d_dev_in", i), g_lat[0].dev_in, tbl[i].exp_di);
            chk($sformatf("tbl%0d_m_valid", i), g_lat[0].m_valid, tbl[i].exp_mv);
            if (tbl[i].exp_mv)
                chk($sformatf("tbl%0d_m_data", i), g_lat[0].m_data, tbl[i].exp_md);
            tick();
        end
        repeat (4) tick();

        g_lat[2].got_n = 0;
        sv = 1'b1; sd = 8'h11; tick();
        sv = 1'b0; tick(); tick();
        sv = 1'b1; sd = 8'h22; tick();
        sv = 1'b0;
        repeat (6) tick();
        chk("gap_count", g_lat[2].got_n, 2);
        chk("gap_first", g_lat[2].got_d[0], 8'hEE);
        chk("gap_second", g_lat[2].got_d[1], 8'hDD);

        mr = 1'b0;
        g_lat[1].got_n = 0;
        n = 0;
        for (int k = 0; k < 8; k++) begin
            sv = 1'b1;
            sd = 8'h30 + 8'(k);
            @(negedge clk);
            if (g_lat[1].s_ready) n++;
            tick();
        end
        chk("fill_issues", n, 4);
        @(negedge clk);
        chk("fill_stall", g_lat[1].s_ready, 0);
        tick();

        mr = 1'b1;
        resumed = 1'b0;
        for (int k = 0; k < 10; k++) begin
            sv = 1'b1;
            sd = 8'h40 + 8'(k);
            @(negedge clk);
            if (g_lat[1].s_ready) resumed = 1'b1;
            tick();
        end
        sv = 1'b0;
        repeat (6) tick();
        chk("drain_resume", resumed, 1);
        chk("drain_pop0", g_lat[1].got_d[0], 8'hCF);
        chk("drain_pop1", g_lat[1].got_d[1], 8'hCE);
        chk("drain_pop2", g_lat[1].got_d[2], 8'hCD);
        chk("drain_pop3", g_lat[1].got_d[3], 8'hCC);

        mr = 1'b0;
        sv = 1'b1; sd = 8'hA1; tick();
        sd = 8'hA2; tick();
        sd = 8'hA3; tick();
        sv = 1'b0;
        rst = 1'b0;
        @(negedge clk);
        chk("mid_m_valid", g_lat[1].m_valid, 0);
        chk("mid_dev_rst", g_lat[1].dev_rst, 1);
        tick();
        rst = 1'b1;
        repeat (3) tick();
        g_lat[1].got_n = 0;
        mr = 1'b1;
        sv = 1'b1; sd = 8'h01; tick();
        sv = 1'b0;
        repeat (5) tick();
        chk("rec_count", g_lat[1].got_n, 1);
        chk("rec_data", g_lat[1].got_d[0], 8'hFE);
`ifdef REWIRE_DRV_STATS_EN
        chk("rec_isc", g_lat[1].isc, 1);
        chk("rec_rtc", g_lat[1].rtc, 1);
`endif

        for (int c = 0; c < 400; c++) begin
            sv  = 1'($urandom_range(0, 1));
            sd  = 8'($urandom);
            mr  = ($urandom_range(0, 3) != 0);
            rst = ($urandom_range(0, 79) != 0);
            tick();
        end
        rst = 1'b1;
        sv  = 1'b0;
        mr  = 1'b1;
        repeat (10) tick();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
